// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : digit_serial_addsub
// Brief   : WIDTH-bit adder/subtractor computing DIGIT bits per clock, LSB
//           digit first, with a start/busy/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [DIGIT:0]   w_digit_sum;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_last;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_last      = (r_state == RUN) && (r_cnt == C_LAST);
    assign w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_a_next   = r_a;
            assign w_b_next   = r_b;
            assign w_acc_next = w_digit_sum[DIGIT-1:0];
        end else begin : g_multi
            // Holds the digits produced so far; the newest digit enters at the top.
            logic [WIDTH-DIGIT-1:0] r_acc;

            assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_acc_next = {w_digit_sum[DIGIT-1:0], r_acc};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_acc <= '0;
                end else if (r_state == RUN) begin
                    r_acc <= w_acc_next[WIDTH-1:DIGIT];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                // Subtraction is a + ~b + ~borrow, so invert b and the carry once here.
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= sub ^ b[WIDTH-1];
                r_carry <= sub ^ c_in;
                r_cnt   <= '0;
                busy    <= 1'b1;
            end else if (r_state == RUN) begin
                r_a     <= w_a_next;
                r_b     <= w_b_next;
                r_carry <= w_digit_sum[DIGIT];
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    y     <= w_acc_next;
                    c_out <= w_digit_sum[DIGIT];
                    ovf   <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_digit_serial_addsub
// Brief   : Bench driving DIGIT=4, DIGIT=1 and DIGIT=16 instances in parallel.
// Rev     : 1.0  initial release
// ============================================================================
module tb_digit_serial_addsub;

    localparam int NI = 3;
    localparam int DIG_V[NI]   = '{4, 1, 16};
    localparam int STEPS_V[NI] = '{4, 16, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        busy_v [NI];
    logic        done_v [NI];
    logic [15:0] y_v    [NI];
    logic        co_v   [NI];
    logic        ov_v   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]), .c_out(co_v[0]), .ovf(ov_v[0]));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]), .c_out(co_v[1]), .ovf(ov_v[1]));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]), .c_out(co_v[2]), .ovf(ov_v[2]));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] y;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [DIGIT=%0d] got=%0h expected=%0h", nm, DIG_V[inst], act, exp);
        end
    endtask

    // Independent reference: full-width unsigned result plus signed range test.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                         input logic mc, output logic [15:0] my, output logic mco,
                         output logic mov);
        logic [16:0] u;
        int          s;
        if (!ms) begin
            u   = {1'b0, ma} + {1'b0, mb} + 17'(mc);
            s   = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
            mco = u[16];
        end else begin
            u   = {1'b0, ma} - {1'b0, mb} - 17'(mc);
            s   = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
            mco = ~u[16];
        end
        my  = u[15:0];
        mov = (s > 32767) || (s < -32768);
    endtask

    // One operation on all three instances; latency, busy length and hold checked per instance.
    task automatic run_all(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                           input logic ts, input logic tc, input logic [15:0] ey,
                           input logic ec, input logic eo);
        int          busy_cnt [NI];
        int          done_cnt [NI];
        int          done_k   [NI];
        int          overlap  [NI];
        int          hold_bad [NI];
        logic [15:0] y_prev   [NI];
        for (int i = 0; i < NI; i++) begin
            busy_cnt[i] = 0; done_cnt[i] = 0; done_k[i] = -1;
            overlap[i]  = 0; hold_bad[i] = 0; y_prev[i] = y_v[i];
        end
        @(negedge clk);
        a = ta; b = tbv; sub = ts; c_in = tc; start = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; a = ~ta; b = ~tbv; sub = ~ts; c_in = ~tc;
            end
            for (int i = 0; i < NI; i++) begin
                if (busy_v[i]) busy_cnt[i]++;
                if (busy_v[i] && done_v[i]) overlap[i]++;
                if (done_v[i]) begin
                    done_cnt[i]++;
                    if (done_k[i] < 0) done_k[i] = k;
                end else if (done_cnt[i] == 0 && y_v[i] !== y_prev[i]) begin
                    hold_bad[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            check({tag, ".busy_cycles"}, i, busy_cnt[i], STEPS_V[i]);
            check({tag, ".done_count"},  i, done_cnt[i], 1);
            check({tag, ".done_edge"},   i, done_k[i], STEPS_V[i]);
            check({tag, ".done_busy"},   i, overlap[i], 0);
            check({tag, ".y_hold"},      i, hold_bad[i], 0);
            check({tag, ".y"},           i, 32'(y_v[i]), 32'(ey));
            check({tag, ".c_out"},       i, 32'(co_v[i]), 32'(ec));
            check({tag, ".ovf"},         i, 32'(ov_v[i]), 32'(eo));
        end
    endtask

    initial begin
        vec_t        vecs[10];
        int          k;
        logic [15:0] ra, rb, my;
        logic        rs, rc, mco, mov;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0007, 16'h0008, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst.busy",  i, 32'(busy_v[i]), 0);
            check("rst.done",  i, 32'(done_v[i]), 0);
            check("rst.y",     i, 32'(y_v[i]), 0);
            check("rst.c_out", i, 32'(co_v[i]), 0);
            check("rst.ovf",   i, 32'(ov_v[i]), 0);
        end
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_all($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].sub,
                    vecs[v].cin, vecs[v].y, vecs[v].co, vecs[v].ov);
        end

        // start pulsed while busy must be ignored (DIGIT=4 instance)
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 16'hFFFF; b = 16'h0F0F; sub = 1'b1; c_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        k = 2;
        while (!done_v[0] && k < 12) begin @(negedge clk); k++; end
        check("ignore.latency", 0, k, 4);
        check("ignore.y",       0, 32'(y_v[0]), 32'h3333);
        check("ignore.c_out",   0, 32'(co_v[0]), 0);
        check("ignore.ovf",     0, 32'(ov_v[0]), 0);
        @(negedge clk);
        check("ignore.no_restart", 0, 32'(busy_v[0]), 0);
        repeat (20) @(negedge clk);

        // Back-to-back: second start sampled in the done cycle
        a = 16'h0100; b = 16'h0200; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!done_v[0] && k < 12) begin @(negedge clk); k++; end
        check("b2b.first_latency", 0, k, 4);
        check("b2b.first_y",       0, 32'(y_v[0]), 32'h0300);
        a = 16'h0F0F; b = 16'h00F1; start = 1'b1;
        @(negedge clk); start = 1'b0; a = '0; b = '0;
        check("b2b.busy_contig", 0, 32'(busy_v[0]), 1);
        check("b2b.done_low",    0, 32'(done_v[0]), 0);
        check("b2b.y_hold",      0, 32'(y_v[0]), 32'h0300);
        k = 0;
        while (!done_v[0] && k < 12) begin @(negedge clk); k++; end
        check("b2b.second_latency", 0, k, 4);
        check("b2b.second_y",       0, 32'(y_v[0]), 32'h1000);
        check("b2b.second_c_out",   0, 32'(co_v[0]), 0);
        repeat (20) @(negedge clk);

        // Asynchronous reset in the second RUN cycle
        a = 16'hAAAA; b = 16'h1111; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst.busy",  0, 32'(busy_v[0]), 0);
        check("arst.done",  0, 32'(done_v[0]), 0);
        check("arst.y",     0, 32'(y_v[0]), 0);
        check("arst.c_out", 0, 32'(co_v[0]), 0);
        check("arst.ovf",   0, 32'(ov_v[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) k++;
        end
        check("arst.no_activity", 0, k, 0);
        run_all("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Random sweep against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rs, rc, my, mco, mov);
            run_all("rand", ra, rb, rs, rc, my, mco, mov);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
